// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into SINGLE NONSEQ
// transfers with one address phase overlapped with one data phase.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR} state_t;

  state_t                  state_q, state_d;
  logic                    ap_valid_q, ap_valid_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [DATA_WIDTH-1:0]   ap_wdata_q, ap_wdata_d;
  logic                    dp_write_q, dp_write_d;
  logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    nonseq;
  logic                    ap_done;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   addr_aligned;

  // The pending address phase stays registered in ERR but is hidden from the bus.
  assign nonseq    = ap_valid_q && (state_q != ST_ERR);
  assign ap_done   = HREADY && nonseq;
  assign cmd_ready = HRESETn && (!ap_valid_q || ap_done) && (state_q != ST_ERR);
  assign accept    = cmd_valid && cmd_ready;

  assign HADDR     = haddr_q;
  assign HTRANS    = nonseq ? 2'b10 : 2'b00;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    addr_aligned = cmd_addr;
    case (cmd_size)
      3'd1:    addr_aligned[0]   = 1'b0;
      3'd2:    addr_aligned[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ap_valid_d  = ap_valid_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    ap_wdata_d  = ap_wdata_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_DATA: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = dp_write_q;
          rsp_rdata_d = dp_write_q ? '0 : HRDATA;
          rsp_err_d   = HRESP;
          state_d     = ST_IDLE;
        end else if (HRESP) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = dp_write_q;
          rsp_rdata_d = dp_write_q ? '0 : HRDATA;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // ap_done implies HREADY, so it never races the DATA->ERR transition.
    if (ap_done) begin
      dp_write_d = hwrite_q;
      hwdata_d   = ap_wdata_q;
      state_d    = ST_DATA;
      ap_valid_d = 1'b0;
    end

    if (accept) begin
      ap_valid_d = 1'b1;
      haddr_d    = addr_aligned;
      hwrite_d   = cmd_write;
      hsize_d    = cmd_size;
      ap_wdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      ap_valid_q  <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      ap_wdata_q  <= '0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ap_valid_q  <= ap_valid_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: transaction-level model of the command/bus/response
// flow plus an in-bench slave with scripted or random wait and error responses.
module tb_ahb_lite_master;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;

  ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
  } cmd_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state: commands awaiting their address phase, the transfer in its
  // data phase, the slave's second ERROR cycle, and the response due next.
  cmd_t        q_ap[$];
  cmd_t        dp;
  bit          dp_v = 0;
  bit          err2 = 0;
  bit          rsp_v_e = 0;
  logic        rsp_w_e;
  logic [31:0] rsp_d_e;
  logic        rsp_e_e;
  bit          post_rst = 1;
  bit          prev_wait = 0;
  logic [31:0] prev_hwdata;
  bit          last_acc;
  bit          random_mode = 0;
  int          slv_script[$];
  logic [31:0] mem [bit [31:0]];

  logic [31:0] rsp_log_d[$];
  logic        rsp_log_w[$];
  logic        rsp_log_e[$];
  int          rsp_log_c[$];
  logic [31:0] ap_log_a[$];
  logic [2:0]  ap_log_s[$];
  int          ap_log_c[$];
  int          acc_c[$];

  function automatic logic [31:0] align(input logic [31:0] a, input logic [2:0] sz);
    if (sz == 3'd1) return a - (a % 2);
    if (sz == 3'd2) return a - (a % 4);
    return a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One bus cycle: drive slave inputs, check at negedge, advance the model.
  task automatic step();
    int   act;
    int   r;
    logic [1:0] htrans_e;
    bit   apdone, ready_e;
    cmd_t c;
    HRESP  = 1'b0;
    HRDATA = $urandom;
    if (dp_v) begin
      if (err2) begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end else begin
        if (slv_script.size() > 0) act = slv_script.pop_front();
        else if (random_mode) begin
          r = $urandom_range(0, 99);
          act = (r < 60) ? 0 : (r < 85) ? 1 : 2;
        end else act = 0;
        HREADY = (act == 0);
        HRESP  = (act == 2);
        if (act == 0 && !dp.w && mem.exists(align(dp.addr, dp.sz)))
          HRDATA = mem[align(dp.addr, dp.sz)];
      end
    end else begin
      HREADY = random_mode ? ($urandom_range(0, 99) < 85) : 1'b1;
    end

    @(negedge HCLK);
    htrans_e = (q_ap.size() > 0 && !err2) ? 2'b10 : 2'b00;
    apdone   = HREADY && (htrans_e == 2'b10);
    ready_e  = HRESETn && (q_ap.size() == 0 || apdone) && !err2;

    chk("htrans", HTRANS, htrans_e);
    chk("cmd_ready", cmd_ready, ready_e);
    chk("hburst", HBURST, 3'b000);
    if (htrans_e == 2'b10) begin
      chk("haddr", HADDR, align(q_ap[0].addr, q_ap[0].sz));
      chk("hwrite", HWRITE, q_ap[0].w);
      chk("hsize", HSIZE, q_ap[0].sz);
    end
    if (dp_v && dp.w) chk("hwdata", HWDATA, dp.wd);
    if (prev_wait) chk("hwdata_hold", HWDATA, prev_hwdata);
    chk("rsp_valid", rsp_valid, rsp_v_e);
    if (rsp_v_e) begin
      chk("rsp_write", rsp_write, rsp_w_e);
      chk("rsp_rdata", rsp_rdata, rsp_d_e);
      chk("rsp_err", rsp_err, rsp_e_e);
    end
    if (post_rst) begin
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", HWRITE, 1'b0);
      chk("rst_hsize", HSIZE, 3'd0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rsp", {rsp_write, rsp_err, rsp_rdata}, 34'h0);
    end

    if (rsp_valid) begin
      rsp_log_d.push_back(rsp_rdata);
      rsp_log_w.push_back(rsp_write);
      rsp_log_e.push_back(rsp_err);
      rsp_log_c.push_back(cyc);
    end
    if (HTRANS == 2'b10 && HREADY) begin
      ap_log_a.push_back(HADDR);
      ap_log_s.push_back(HSIZE);
      ap_log_c.push_back(cyc);
    end

    prev_wait   = dp_v && !HREADY && !HRESP && !err2;
    prev_hwdata = HWDATA;
    rsp_v_e     = 0;
    if (dp_v) begin
      if (HREADY) begin
        rsp_v_e = 1;
        rsp_w_e = dp.w;
        rsp_d_e = dp.w ? 32'h0 : HRDATA;
        rsp_e_e = err2 ? 1'b1 : HRESP;
        if (dp.w && !err2 && !HRESP) mem[align(dp.addr, dp.sz)] = dp.wd;
        dp_v = 0;
        err2 = 0;
      end else if (HRESP) begin
        err2 = 1;
      end
    end
    if (apdone) begin
      dp   = q_ap.pop_front();
      dp_v = 1;
    end
    last_acc = cmd_valid && ready_e;
    if (last_acc) begin
      c.w = cmd_write; c.sz = cmd_size; c.addr = cmd_addr; c.wd = cmd_wdata;
      q_ap.push_back(c);
      acc_c.push_back(cyc);
    end
    post_rst = !HRESETn;
    if (!HRESETn) begin
      q_ap.delete();
      slv_script.delete();
      dp_v = 0; err2 = 0; rsp_v_e = 0; prev_wait = 0;
    end
    cyc++;
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q_ap.size() == 0 && !dp_v && !rsp_v_e) break;
      step();
    end
    chk("drain_timeout", (q_ap.size() == 0 && !dp_v && !rsp_v_e), 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, a0, c0;
    HRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 3'd2;
    cmd_addr = 32'h4; cmd_wdata = 32'h1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    @(posedge HCLK); #1;

    // T1: reset held with a command offered
    step(); step();
    chk("t1_ready_in_reset", cmd_ready, 1'b0);
    HRESETn = 1'b1; cmd_valid = 1'b0;
    #1;
    chk("t1_ready_after", cmd_ready, 1'b1);
    step();

    // T2: zero-wait write then read of the same word
    r0 = rsp_log_d.size(); a0 = ap_log_a.size(); c0 = acc_c.size();
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    drain();
    chk("t2_rsp_count", rsp_log_d.size() - r0, 2);
    if (rsp_log_d.size() >= r0 + 2 && ap_log_c.size() >= a0 + 2) begin
      chk("t2_read_data", rsp_log_d[r0 + 1], 32'hDEADBEEF);
      chk("t2_write_dir", rsp_log_w[r0], 1'b1);
      chk("t2_haddr", ap_log_a[a0], 32'h10);
      chk("t2_nonseq_consec", ap_log_c[a0 + 1] - ap_log_c[a0], 1);
      chk("t2_latency", rsp_log_c[r0] - acc_c[c0], 3);
    end

    // T3: three wait states on a read with a write pipelined behind it
    r0 = rsp_log_d.size(); a0 = ap_log_a.size(); c0 = acc_c.size();
    slv_script = '{1, 1, 1, 0, 0};
    issue(1'b0, 3'd2, 32'h20, 32'h0);
    issue(1'b1, 3'd2, 32'h24, 32'h12345678);
    drain();
    chk("t3_rsp_count", rsp_log_d.size() - r0, 2);
    if (rsp_log_d.size() >= r0 + 2 && ap_log_c.size() >= a0 + 2) begin
      chk("t3_read_latency", rsp_log_c[r0] - acc_c[c0], 6);
      chk("t3_wr_ap_cycle", ap_log_c[a0 + 1] - acc_c[c0], 5);
      chk("t3_wr_haddr", ap_log_a[a0 + 1], 32'h24);
    end

    // T4: ERROR on a write with a read pipelined behind it
    r0 = rsp_log_d.size(); a0 = ap_log_a.size(); c0 = acc_c.size();
    slv_script = '{2};
    issue(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5);
    issue(1'b0, 3'd2, 32'h44, 32'h0);
    drain();
    chk("t4_rsp_count", rsp_log_d.size() - r0, 2);
    if (rsp_log_d.size() >= r0 + 2 && ap_log_c.size() >= a0 + 2) begin
      chk("t4_err_first", rsp_log_e[r0], 1'b1);
      chk("t4_err_second", rsp_log_e[r0 + 1], 1'b0);
      chk("t4_err_latency", rsp_log_c[r0] - acc_c[c0], 4);
      chk("t4_reissue_addr", ap_log_a[a0 + 1], 32'h44);
      chk("t4_reissue_cycle", ap_log_c[a0 + 1] - acc_c[c0], 4);
    end

    // T5: size-driven address alignment
    a0 = ap_log_a.size();
    issue(1'b0, 3'd2, 32'h13, 32'h0);
    issue(1'b0, 3'd1, 32'h13, 32'h0);
    drain();
    chk("t5_ap_count", ap_log_a.size() - a0, 2);
    if (ap_log_a.size() >= a0 + 2) begin
      chk("t5_word_addr", ap_log_a[a0], 32'h10);
      chk("t5_half_addr", ap_log_a[a0 + 1], 32'h12);
      chk("t5_half_size", ap_log_s[a0 + 1], 3'd1);
    end

    // T6: reset during a waited data phase drops the transfer
    r0 = rsp_log_d.size();
    slv_script = '{1, 1, 1, 1, 1, 1};
    issue(1'b0, 3'd2, 32'h80, 32'h0);
    step(); step();
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t6_no_rsp", rsp_log_d.size() - r0, 0);

    // Randomised traffic with random waits, errors and rare resets
    random_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 70);
      cmd_write = $urandom_range(0, 1);
      cmd_size  = 3'($urandom_range(0, 2));
      cmd_addr  = $urandom & 32'hFF;
      cmd_wdata = $urandom;
      HRESETn   = ($urandom_range(0, 499) != 0);
      step();
    end
    HRESETn = 1'b1;
    random_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
